// File: rtl/scratchpad_backdoor_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : scratchpad_backdoor_arbiter_if
// Brief    : Bundle of requester-side and memory-wrapper-side signals shared
//            between the backdoor arbiter and its environment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface scratchpad_backdoor_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16
);
    // Requester side
    logic                    busy_i;
    logic [NUM_REQ-1:0]      req_i;
    logic [NUM_REQ-1:0]      we_i;
    logic [NUM_REQ*32-1:0]   addr_i;
    logic [NUM_REQ*64-1:0]   wdata_i;
    logic [NUM_REQ-1:0]      ack_o;
    logic [63:0]             rdata_o;
    logic                    err_o;

    // Memory wrapper side
    logic                    mem_sel_o;
    logic [7:0]              mem_mask_o;
    logic                    mem_write_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [63:0]             mem_wdata_o;
    logic [63:0]             mem_rdata_i;

    // Environment: requesters, functional-path busy and the memory wrapper
    modport master (
        output busy_i, req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        input  ack_o, rdata_o, err_o,
               mem_sel_o, mem_mask_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    // The arbiter itself
    modport slave (
        input  busy_i, req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        output ack_o, rdata_o, err_o,
               mem_sel_o, mem_mask_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/scratchpad_backdoor_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : scratchpad_backdoor_arbiter
// Brief    : Round-robin arbiter giving NUM_REQ backdoor requesters exclusive,
//            sequenced 64-bit access to the scratchpad wrapper port while the
//            functional path is idle.
//            Optional feature macro: SCRATCHPAD_ARB_BOUNDS_CHECK_EN
//              defined   -> out-of-range word addresses ack immediately with
//                           err_o=1 and rdata_o=0, no memory access
//              undefined -> addresses wrap within ADDR_W word bits
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module scratchpad_backdoor_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DEPTH_WORDS = 65536,
    parameter int ADDR_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    scratchpad_backdoor_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Parameter consistency is checked at elaboration
    if (ADDR_W != $clog2(DEPTH_WORDS) || NUM_REQ < 2 || NUM_REQ > 4) begin : g_param_error
        $error("scratchpad_backdoor_arbiter: inconsistent NUM_REQ/DEPTH_WORDS/ADDR_W");
    end

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_g;
    logic                r_we;

    logic [NUM_REQ-1:0]  r_ack;
    logic [63:0]         r_rdata;
    logic                r_err;
    logic                r_mem_sel;
    logic [7:0]          r_mem_mask;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [63:0]         r_mem_wdata;

    logic                w_grant_vld;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_word;
    logic [63:0]         w_win_wdata;

    // Round-robin search from r_ptr; the k=0 candidate is visited last so it wins
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_i[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Winner's command fields; only the word-index bits of the address are kept
    assign w_win_we    = bus.we_i[w_grant_idx];
    assign w_win_word  = bus.addr_i[32*w_grant_idx + 3 +: ADDR_W];
    assign w_win_wdata = bus.wdata_i[64*w_grant_idx +: 64];

`ifdef SCRATCHPAD_ARB_BOUNDS_CHECK_EN
    logic [28:0] w_win_word_full;
    logic        w_oob;

    assign w_win_word_full = bus.addr_i[32*w_grant_idx + 3 +: 29];
    assign w_oob           = ({3'b000, w_win_word_full} >= 32'(DEPTH_WORDS));
`endif

    // Transaction sequencer; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_g         <= '0;
            r_we        <= 1'b0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_mask  <= '0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld && !bus.busy_i) begin
                        r_g  <= w_grant_idx;
                        r_we <= w_win_we;
`ifdef SCRATCHPAD_ARB_BOUNDS_CHECK_EN
                        if (w_oob) begin
                            // Out of range: skip the memory entirely
                            r_state <= S_ACK;
                            r_ack   <= c_ONE << w_grant_idx;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state     <= S_CMD;
                            r_err       <= 1'b0;
                            r_mem_sel   <= 1'b1;
                            r_mem_mask  <= 8'hFF;
                            r_mem_write <= w_win_we;
                            r_mem_addr  <= w_win_word;
                            r_mem_wdata <= w_win_we ? w_win_wdata : 64'd0;
                        end
`else
                        r_state     <= S_CMD;
                        r_err       <= 1'b0;
                        r_mem_sel   <= 1'b1;
                        r_mem_mask  <= 8'hFF;
                        r_mem_write <= w_win_we;
                        r_mem_addr  <= w_win_word;
                        r_mem_wdata <= w_win_we ? w_win_wdata : 64'd0;
`endif
                    end
                end
                S_CMD: begin
                    if (r_we) begin
                        r_state     <= S_ACK;
                        r_ack       <= c_ONE << r_g;
                        r_mem_sel   <= 1'b0;
                        r_mem_mask  <= '0;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end else begin
                        // Hold select and address while the wrapper returns data
                        r_state     <= S_CAPT;
                        r_mem_write <= 1'b0;
                        r_mem_wdata <= '0;
                    end
                end
                S_CAPT: begin
                    r_state     <= S_ACK;
                    r_ack       <= c_ONE << r_g;
                    r_rdata     <= bus.mem_rdata_i;
                    r_mem_sel   <= 1'b0;
                    r_mem_mask  <= '0;
                    r_mem_write <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_ptr   <= (r_g == IDX_W'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o       = r_ack;
    assign bus.rdata_o     = r_rdata;
    assign bus.err_o       = r_err;
    assign bus.mem_sel_o   = r_mem_sel;
    assign bus.mem_mask_o  = r_mem_mask;
    assign bus.mem_write_o = r_mem_write;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/scratchpad_backdoor_arbiter.md
# scratchpad_backdoor_arbiter

Shares the scratchpad (main memory) wrapper port between NUM_REQ backdoor requesters, such as the system thread, the loader and the DMI helper, plus the functional path. Requests are granted round-robin, but only while the functional path is idle. Each granted transaction is sequenced as a single 64-bit write or registered read, driving mask, write, address and write data to the wrapper. The block replaces ad-hoc force/release access so that concurrent threads can never drive the memory inputs simultaneously.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, 2..4.
- DEPTH_WORDS, 65536: scratchpad depth in 64-bit words.
- ADDR_W, 16: word-address width, equal to clog2(DEPTH_WORDS).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- busy_i  in  1  functional path owns the memory this cycle; blocks new grants.
- req_i  in  NUM_REQ  per-requester request, held until its ack.
- we_i  in  NUM_REQ  1 = write, 0 = read.
- addr_i  in  NUM_REQ*32  byte addresses; slot i is bits [32i+31:32i].
- wdata_i  in  NUM_REQ*64  write data per slot.
- ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rdata_o  out  64  read data, valid with ack, held until the next ack.
- err_o  out  1  out-of-range flag, valid with ack.
- mem_sel_o  out  1  steers the wrapper input mux to the backdoor.
- mem_mask_o  out  8  byte mask.
- mem_write_o  out  1  write strobe.
- mem_addr_o  out  ADDR_W  word address.
- mem_wdata_o  out  64  write data.
- mem_rdata_i  in  64  wrapper read data, registered one cycle after the address.

## Operation
- FSM states: IDLE, CMD, CAPT, ACK.
- IDLE:
  - If any req_i is high and busy_i is low, pick the winner round-robin from pointer ptr.
  - Latch the winner's we, addr and wdata and its index g, then go to CMD.
  - Otherwise stay in IDLE.
- CMD, one cycle:
  - mem_sel_o=1, mem_mask_o=8'hFF, mem_addr_o=addr[ADDR_W+2:3], mem_write_o=we.
  - mem_wdata_o=wdata when we=1, otherwise 0.
  - Next state: write goes to ACK; read goes to CAPT.
- CAPT, one cycle:
  - mem_sel_o=1, mem_write_o=0, mem_addr_o held.
  - mem_rdata_i is captured into the rdata register at the end of the cycle; go to ACK.
- ACK, one cycle:
  - ack_o[g]=1 and err_o is valid.
  - ptr=(g+1) mod NUM_REQ, then go to IDLE.
- Round-robin search order is ptr, ptr+1, ... with wrap-around; ptr=0 after reset.
- The requester samples ack_o at the clock edge and drops req_i on that edge, so its req is already low when the FSM returns to IDLE.
- busy_i is only examined in IDLE. Once CMD is entered the transaction completes regardless of busy_i.
- The upper address bits above ADDR_W+2 and addr[2:0] are ignored for memory indexing; byte offsets are not supported.
- A write leaves rdata_o unchanged.
- Outside CMD and CAPT, all mem_* outputs are 0.

## Timing
- Request seen in IDLE at cycle T:
  - CMD at T+1.
  - Write ack at T+2.
  - Read: CAPT at T+2, ack and rdata_o at T+3.
- Back-to-back requests: next grant evaluated in IDLE at ack+1. Minimum issue interval is 3 cycles for writes and 4 for reads.
- Simultaneous requests: exactly one grant per IDLE evaluation, in strict rotation from ptr. No requester waits more than NUM_REQ transactions once busy_i stays low.
- busy_i held high: requests wait indefinitely with no ack and no timeout.
- rst high at any clock edge:
  - Next state is IDLE, ptr=0, and the latched request is discarded with no ack.
  - Reset values: ack_o=0, rdata_o=0, err_o=0, mem_sel_o=0, mem_mask_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SCRATCHPAD_ARB_BOUNDS_CHECK_EN defined:
  - In IDLE, the latched addr[31:3] is compared with DEPTH_WORDS.
  - If addr[31:3] >= DEPTH_WORDS, the FSM goes directly from IDLE to ACK, skipping CMD and CAPT, with no memory access.
  - It then asserts err_o=1 and rdata_o=0. Ack latency for this case is T+1.
- SCRATCHPAD_ARB_BOUNDS_CHECK_EN undefined:
  - No comparison is made and err_o stays 0.
  - Addresses are truncated to ADDR_W word bits and wrap within the memory.

## Test plan
- Single write, then read: req0 writes 64'hDEADBEEF_CAFEF00D to byte 0x100. Required: mem_write_o=1 and mem_addr_o=0x20 at T+1, ack_o[0] at T+2. The read-back gets ack_o[0] at T+3 with rdata_o equal to the written value.
- Contention: req0, req1 and req2 all assert in the same cycle after reset. Required: grant order 0,1,2. Re-asserting all three afterwards gives order 0,1,2 again because ptr wraps.
- busy_i held high for 10 cycles with req1 pending: no CMD occurs during those cycles. CMD occurs one cycle after busy_i falls, and ack follows 1 cycle later (write) or 2 cycles later (read).
- Reset mid-read: assert rst during CAPT. Required: no ack, all outputs 0 at the next cycle, and a subsequent request is granted normally with ptr=0.
- Bounds check, with SCRATCHPAD_ARB_BOUNDS_CHECK_EN and DEPTH_WORDS=16: a read of byte 0x80 acks at T+1 with err_o=1, rdata_o=0 and mem_sel_o never asserted. Without the macro, the same read accesses word 0.
